alu_seq_ctrl: RTL

Multi-cycle sequencer in front of the combinational MIPS-style `alu` (operands gr1/gr2, instruction i_datain, outputs c/zon/hi/lo). It accepts one instruction at a time over a valid/ready handshake and holds the ALU inputs stable for the required number of cycles. It owns the architectural HI/LO registers and returns a registered result to the writeback stage over a second valid/ready handshake.

---
 rtl/alu_seq_pkg.sv | 39 +++
 rtl/alu_op_decode.sv | 40 ++++
 rtl/alu_seq_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared states, opcode/funct constants and decode record for
//               the ALU sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_MD_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef struct packed {
        logic is_muldiv;
        logic is_div;
        logic is_mfhi;
        logic is_mflo;
        logic is_mthi;
        logic is_mtlo;
        logic wb;
    } dec_t;

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decode
// Description : Combinational classification of an instruction word into the
//               HI/LO and multi-cycle categories the sequencer cares about.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [31:0] instr,
    output logic        is_muldiv,
    output logic        is_div,
    output logic        is_mfhi,
    output logic        is_mflo,
    output logic        is_mthi,
    output logic        is_mtlo,
    output logic        wb
);

    logic       w_rtype;
    logic [5:0] w_funct;
    logic       w_unused;

    assign w_rtype  = (instr[31:26] == OP_RTYPE);
    assign w_funct  = instr[5:0];
    assign w_unused = ^instr[25:6];

    assign is_muldiv = w_rtype && ((w_funct == FN_MULT) || (w_funct == FN_MULTU) ||
                                   (w_funct == FN_DIV)  || (w_funct == FN_DIVU));
    assign is_div    = w_rtype && ((w_funct == FN_DIV) || (w_funct == FN_DIVU));
    assign is_mfhi   = w_rtype && (w_funct == FN_MFHI);
    assign is_mflo   = w_rtype && (w_funct == FN_MFLO);
    assign is_mthi   = w_rtype && (w_funct == FN_MTHI);
    assign is_mtlo   = w_rtype && (w_funct == FN_MTLO);
    // Only HI/LO writers and mult/div leave the GPR file untouched
    assign wb        = !(is_muldiv || is_mthi || is_mtlo);

endmodule
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl
// Description : Multi-cycle sequencer in front of a combinational ALU; owns
//               HI/LO and returns one registered result per instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int MULDIV_LAT = 4,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_rs,
    input  logic [DATA_W-1:0] in_rt,
    output logic [DATA_W-1:0] alu_gr1,
    output logic [DATA_W-1:0] alu_gr2,
    output logic [31:0]       alu_instr,
    input  logic [DATA_W-1:0] alu_c,
    input  logic [2:0]        alu_zon,
    input  logic [DATA_W-1:0] alu_hi,
    input  logic [DATA_W-1:0] alu_lo,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [2:0]        out_zon,
    output logic              out_wb,
    output logic              out_div0,
    output logic [DATA_W-1:0] hi_q,
    output logic [DATA_W-1:0] lo_q
);

    localparam logic [3:0] C_CNT_LOAD = 4'(MULDIV_LAT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_instr;
    logic [DATA_W-1:0] r_rs;
    logic [DATA_W-1:0] r_rt;
    logic [3:0]        r_cnt;
    dec_t              r_dec;
    dec_t              w_dec_in;

    logic w_is_muldiv, w_is_div, w_is_mfhi, w_is_mflo, w_is_mthi, w_is_mtlo, w_wb;

    alu_op_decode u_dec (
        .instr     (in_instr),
        .is_muldiv (w_is_muldiv),
        .is_div    (w_is_div),
        .is_mfhi   (w_is_mfhi),
        .is_mflo   (w_is_mflo),
        .is_mthi   (w_is_mthi),
        .is_mtlo   (w_is_mtlo),
        .wb        (w_wb)
    );

    assign w_dec_in = '{w_is_muldiv, w_is_div, w_is_mfhi, w_is_mflo,
                        w_is_mthi, w_is_mtlo, w_wb};

    assign alu_gr1   = r_rs;
    assign alu_gr2   = r_rt;
    assign alu_instr = r_instr;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = !rst;
                if (in_valid)
                    w_state_nxt = w_dec_in.is_muldiv ? ST_MD_WAIT : ST_EXEC;
            end
            ST_EXEC:    w_state_nxt = ST_RESP;
            ST_MD_WAIT: if (r_cnt == 4'd0) w_state_nxt = ST_RESP;
            ST_RESP: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr    <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_cnt      <= '0;
            r_dec      <= '0;
            out_result <= '0;
            out_zon    <= '0;
            out_wb     <= 1'b0;
            out_div0   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_instr <= in_instr;
                        r_rs    <= in_rs;
                        r_rt    <= in_rt;
                        r_dec   <= w_dec_in;
                        r_cnt   <= w_dec_in.is_muldiv ? C_CNT_LOAD : 4'd0;
                    end
                end
                ST_EXEC: begin
                    out_wb   <= r_dec.wb;
                    out_div0 <= 1'b0;
                    out_zon  <= '0;
                    if (r_dec.is_mfhi)
                        out_result <= hi_q;
                    else if (r_dec.is_mflo)
                        out_result <= lo_q;
                    else if (r_dec.is_mthi || r_dec.is_mtlo)
                        out_result <= '0;
                    else begin
                        out_result <= alu_c;
                        out_zon    <= alu_zon;
                    end
                    if (r_dec.is_mthi) hi_q <= r_rs;
                    if (r_dec.is_mtlo) lo_q <= r_rs;
                end
                ST_MD_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        out_result <= '0;
                        out_wb     <= 1'b0;
                        out_zon    <= '0;
                        // Divide by zero keeps HI/LO and only raises the flag
                        if (r_dec.is_div && (r_rt == '0)) begin
                            out_div0 <= 1'b1;
                        end else begin
                            hi_q <= alu_hi;
                            lo_q <= alu_lo;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (out_ready) begin
                        out_result <= '0;
                        out_zon    <= '0;
                        out_wb     <= 1'b0;
                        out_div0   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
